// File: rtl/tcp_tx_pkg.sv
// Shared definitions for the TX stream packer: geometry, FSM states and
// the byte-count helpers used when a word is loaded and serialized.
package tcp_tx_pkg;

   localparam int DATA_BITS  = 512;
   localparam int OUT_BITS   = 64;
   localparam int BEATS      = DATA_BITS / OUT_BITS;
   localparam int KEEP_W     = OUT_BITS / 8;
   localparam int BEAT_W     = $clog2(BEATS);
   localparam int NB_W       = BEAT_W + 1;
   localparam int BYTES_W    = 7;
   localparam int WORD_BYTES = DATA_BITS / 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   // Out-of-range byte counts (0 or beyond a full word) mean a full word.
   function automatic logic [BYTES_W-1:0] norm_bytes(input logic [BYTES_W-1:0] b);
      if (b == '0 || b > BYTES_W'(WORD_BYTES)) return BYTES_W'(WORD_BYTES);
      return b;
   endfunction

   // Beats needed for a word: ceil(bytes/lane) for a last word, else all lanes.
   function automatic logic [NB_W-1:0] calc_nbeats(input logic last,
                                                    input logic [BYTES_W-1:0] b);
      logic [BYTES_W-1:0] sum;
      sum = b + BYTES_W'(KEEP_W - 1);
      if (!last) return NB_W'(BEATS);
      return NB_W'(sum >> $clog2(KEEP_W));
   endfunction

   // Byte enables for the final beat: low 'residual' bytes set.
   function automatic logic [KEEP_W-1:0] keep_mask(input logic last,
                                                   input logic [BYTES_W-1:0] b,
                                                   input logic [NB_W-1:0] nb);
      logic [BYTES_W-1:0] res;
      logic [KEEP_W-1:0]  ones;
      ones = '1;
      if (!last) return ones;
      res = b - (BYTES_W'(nb - NB_W'(1)) << $clog2(KEEP_W));
      return ~(ones << res);
   endfunction

endpackage

// File: rtl/tx_stream_packer_if.sv
// Word input from the BRAM read stage plus AXI-Stream beat output.
// 'master' is the read-stage/sink side, 'slave' is the packer.
interface tx_stream_packer_if #(
   parameter int data_bits  = 512,
   parameter int out_bits   = 64,
   parameter int fifo_depth = 4
);
   logic [data_bits-1:0]          fifo_tx_data;
   logic                          fifo_tx_valid;
   logic                          word_last;
   logic [6:0]                    word_bytes;
   logic                          fifo_tx_ready;
   logic [out_bits-1:0]           m_axis_tdata;
   logic [out_bits/8-1:0]         m_axis_tkeep;
   logic                          m_axis_tvalid;
   logic                          m_axis_tlast;
   logic                          m_axis_tready;
   logic [$clog2(fifo_depth):0]   fifo_level;

   modport master (
      output fifo_tx_data, fifo_tx_valid, word_last, word_bytes, m_axis_tready,
      input  fifo_tx_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
             m_axis_tlast, fifo_level
   );

   modport slave (
      input  fifo_tx_data, fifo_tx_valid, word_last, word_bytes, m_axis_tready,
      output fifo_tx_ready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
             m_axis_tlast, fifo_level
   );
endinterface

// File: rtl/tx_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags and occupancy.
// Push while full and pop while empty are ignored.
module tx_sync_fifo #(
   parameter int WIDTH = 520,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [LW-1:0]    level_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, empty_q;
   logic             push_ok, pop_ok;

   assign push_ok = push_i && !full_q;
   assign pop_ok  = pop_i && !empty_q;

   // Next pointers wrap naturally (power-of-two depth); level tracks net change.
   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push_ok);
      rd_ptr_d = rd_ptr_q + AW'(pop_ok);
      level_d  = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   // Control state: pointers, level and flags registered from next level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= (level_d == LW'(DEPTH));
         empty_q  <= (level_d == '0);
      end
   end

   // Storage array; data needs no reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign level_o = level_q;

endmodule

// File: rtl/tx_stream_packer.sv
// Buffers 512-bit words from the read stage and serializes each into
// 64-bit AXI-Stream beats, generating tkeep/tlast for partial last words.
module tx_stream_packer
   import tcp_tx_pkg::*;
#(
   parameter int data_bits  = DATA_BITS,
   parameter int out_bits   = OUT_BITS,
   parameter int fifo_depth = 4
) (
   input  logic                clk,
   input  logic                reset,
   tx_stream_packer_if.slave   bus
);

   localparam int ENTRY_W = data_bits + 1 + BYTES_W;

   logic [ENTRY_W-1:0]   wr_entry, rd_entry;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop;
   logic [data_bits-1:0] head_data;
   logic                 head_last;
   logic [BYTES_W-1:0]   head_bytes;
   logic [NB_W-1:0]      head_nbeats;

   state_t               state_q;
   logic [data_bits-1:0] shift_q;
   logic                 last_q;
   logic [BYTES_W-1:0]   bytes_q;
   logic [NB_W-1:0]      nbeats_q;
   logic [BEAT_W-1:0]    beat_q;
   logic                 tvalid_q;
   logic                 tlast_q;
   logic                 final_beat;
   logic                 beat_hs;

   // Byte count is normalized on entry so the FIFO only holds legal values.
   assign push     = bus.fifo_tx_valid && !fifo_full;
   assign wr_entry = {bus.fifo_tx_data, bus.word_last, norm_bytes(bus.word_bytes)};

   tx_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (fifo_depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push),
      .din_i   (wr_entry),
      .pop_i   (pop),
      .dout_o  (rd_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (bus.fifo_level)
   );

   assign {head_data, head_last, head_bytes} = rd_entry;
   assign head_nbeats = calc_nbeats(head_last, head_bytes);

   assign final_beat = (NB_W'(beat_q) == nbeats_q - NB_W'(1));
   assign beat_hs    = tvalid_q && bus.m_axis_tready;

   // Pop from IDLE, or on the final-beat handshake for a bubble-free reload.
   assign pop = !fifo_empty &&
                ((state_q == IDLE) || (state_q == SEND && beat_hs && final_beat));

   // Serializer FSM with registered tvalid/tlast.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 1'b0;
         bytes_q  <= '0;
         nbeats_q <= '0;
         beat_q   <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_q  <= SEND;
                  last_q   <= head_last;
                  bytes_q  <= head_bytes;
                  nbeats_q <= head_nbeats;
                  beat_q   <= '0;
                  tlast_q  <= head_last && (head_nbeats == NB_W'(1));
                  tvalid_q <= 1'b0;
               end
            end
            SEND: begin
               if (!tvalid_q) begin
                  tvalid_q <= 1'b1;
               end else if (bus.m_axis_tready) begin
                  if (final_beat) begin
                     if (!fifo_empty) begin
                        last_q   <= head_last;
                        bytes_q  <= head_bytes;
                        nbeats_q <= head_nbeats;
                        beat_q   <= '0;
                        tlast_q  <= head_last && (head_nbeats == NB_W'(1));
                     end else begin
                        state_q  <= IDLE;
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        beat_q   <= '0;
                     end
                  end else begin
                     beat_q  <= beat_q + BEAT_W'(1);
                     tlast_q <= last_q && (NB_W'(beat_q) + NB_W'(2) == nbeats_q);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Shift register captures the popped word; held until the next pop.
   always_ff @(posedge clk) begin
      if (pop) shift_q <= head_data;
   end

   assign bus.fifo_tx_ready = !fifo_full;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign bus.m_axis_tdata  = tvalid_q ? shift_q[int'(beat_q)*out_bits +: out_bits] : '0;
   assign bus.m_axis_tkeep  = !tvalid_q  ? '0 :
                              final_beat ? keep_mask(last_q, bytes_q, nbeats_q) : '1;

endmodule

// File: tb/tb_tx_stream_packer.sv
// Directed bench for tx_stream_packer with a beat-level reference queue.
module tb_tx_stream_packer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tx_stream_packer_if tif ();

   tx_stream_packer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (tif)
   );

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t       exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [63:0] log_d [256];
   logic [7:0]  log_k [256];
   logic        log_l [256];
   int          log_c [256];
   int          log_n = 0;
   logic [63:0] ref_d [48];
   logic        rand_rdy = 1'b0;
   logic        prev_stall = 1'b0;
   logic        saw_full = 1'b0;
   int          stalls = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] make_word(input int seed);
      logic [511:0] w;
      for (int i = 0; i < 64; i++) w[8*i +: 8] = 8'(seed + i);
      return w;
   endfunction

   // Expected beats from byte-level rules: byte b of the word is valid if b < effective count.
   task automatic model_push(input logic [511:0] w, input logic last, input logic [6:0] bytes);
      int    eff, nb;
      beat_t b;
      eff = 64;
      if (last && bytes != 0 && bytes <= 64) eff = int'(bytes);
      nb = (eff + 7) / 8;
      for (int k = 0; k < nb; k++) begin
         b.d = w[64*k +: 64];
         for (int j = 0; j < 8; j++) b.k[j] = ((8*k + j) < eff);
         b.l = last && (k == nb - 1);
         exp_q.push_back(b);
      end
   endtask

   // Called at #1 after a rising edge; returns at #1 after the push edge.
   task automatic push_word(input logic [511:0] w, input logic last, input logic [6:0] bytes);
      int waited;
      waited = 0;
      tif.fifo_tx_data  = w;
      tif.word_last     = last;
      tif.word_bytes    = bytes;
      tif.fifo_tx_valid = 1'b1;
      @(negedge clk);
      while (!tif.fifo_tx_ready && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (!tif.fifo_tx_ready) check("push_timeout", 64'd0, 64'd1);
      else model_push(w, last, bytes);
      @(posedge clk);
      #1;
      tif.fifo_tx_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || tif.m_axis_tvalid) && n < 600) begin
         n++;
         @(negedge clk);
      end
      check("drain", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Per-cycle comparison against the reference queue.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            check("ready_vs_level", 64'(tif.fifo_tx_ready), 64'(tif.fifo_level != 3'd4));
            if (tif.fifo_level == 3'd4 && !tif.fifo_tx_ready) saw_full = 1'b1;
            if (prev_stall && !tif.m_axis_tvalid) check("valid_held", 64'd0, 64'd1);
            if (tif.m_axis_tvalid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 64'd1, 64'd0);
               end else begin
                  check("tdata", tif.m_axis_tdata, exp_q[0].d);
                  check("tkeep", 64'(tif.m_axis_tkeep), 64'(exp_q[0].k));
                  check("tlast", 64'(tif.m_axis_tlast), 64'(exp_q[0].l));
               end
               if (tif.m_axis_tready) begin
                  if (log_n < 256) begin
                     log_d[log_n] = tif.m_axis_tdata;
                     log_k[log_n] = tif.m_axis_tkeep;
                     log_l[log_n] = tif.m_axis_tlast;
                     log_c[log_n] = cyc;
                     log_n++;
                  end
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
               end else begin
                  stalls++;
               end
            end
            prev_stall = tif.m_axis_tvalid && !tif.m_axis_tready;
         end
      end
   end

   // Random back-pressure when enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) tif.m_axis_tready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int mm;
      reset             = 1'b1;
      tif.fifo_tx_data  = '0;
      tif.fifo_tx_valid = 1'b0;
      tif.word_last     = 1'b0;
      tif.word_bytes    = 7'd0;
      tif.m_axis_tready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready",  64'(tif.fifo_tx_ready), 64'd1);
      check("rst_tvalid", 64'(tif.m_axis_tvalid), 64'd0);
      check("rst_tlast",  64'(tif.m_axis_tlast),  64'd0);
      check("rst_tdata",  tif.m_axis_tdata,       64'd0);
      check("rst_tkeep",  64'(tif.m_axis_tkeep),  64'd0);
      check("rst_level",  64'(tif.fifo_level),    64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Full last word, byte i = i; also first-beat latency.
      log_n = 0;
      push_word(make_word(0), 1'b1, 7'd64);
      @(negedge clk);
      check("lat_edgeN",  64'(tif.m_axis_tvalid), 64'd0);
      @(negedge clk);
      check("lat_edgeN1", 64'(tif.m_axis_tvalid), 64'd0);
      @(negedge clk);
      check("lat_edgeN2", 64'(tif.m_axis_tvalid), 64'd1);
      wait_drain();
      check("t1_count", 64'(log_n), 64'd8);
      check("t1_beat0", log_d[0], 64'h0706050403020100);
      check("t1_beat7", log_d[7], 64'h3F3E3D3C3B3A3938);
      check("t1_keep3", 64'(log_k[3]), 64'hFF);
      check("t1_keep7", 64'(log_k[7]), 64'hFF);
      check("t1_last6", 64'(log_l[6]), 64'd0);
      check("t1_last7", 64'(log_l[7]), 64'd1);

      // Partial last word, 19 bytes.
      log_n = 0;
      push_word(make_word(8'h40), 1'b1, 7'd19);
      wait_drain();
      check("t2_count", 64'(log_n), 64'd3);
      check("t2_keep0", 64'(log_k[0]), 64'hFF);
      check("t2_keep1", 64'(log_k[1]), 64'hFF);
      check("t2_keep2", 64'(log_k[2]), 64'h07);
      check("t2_beat2", log_d[2], 64'h5756555453525150);
      check("t2_last1", 64'(log_l[1]), 64'd0);
      check("t2_last2", 64'(log_l[2]), 64'd1);

      // Six words back-to-back, tready held high.
      log_n    = 0;
      saw_full = 1'b0;
      for (int i = 0; i < 6; i++) push_word(make_word(17 * i), 1'(i == 5), 7'd64);
      wait_drain();
      check("t3_count",    64'(log_n), 64'd48);
      check("t3_saw_full", 64'(saw_full), 64'd1);
      check("t3_no_gap",   64'(log_c[47] - log_c[0]), 64'd47);
      check("t3_w1_beat0", log_d[8], 64'h1817161514131211);
      check("t3_last7",    64'(log_l[7]), 64'd0);
      check("t3_last47",   64'(log_l[47]), 64'd1);
      for (int i = 0; i < 48; i++) ref_d[i] = log_d[i];

      // Same six words under random back-pressure.
      log_n    = 0;
      stalls   = 0;
      rand_rdy = 1'b1;
      for (int i = 0; i < 6; i++) push_word(make_word(17 * i), 1'(i == 5), 7'd64);
      wait_drain();
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      tif.m_axis_tready = 1'b1;
      mm = 0;
      for (int i = 0; i < 48; i++) if (log_d[i] !== ref_d[i]) mm++;
      check("t4_count",     64'(log_n), 64'd48);
      check("t4_same_data", 64'(mm), 64'd0);
      check("t4_stalled",   64'(stalls > 0), 64'd1);

      // Reset during beat 3 with two words queued.
      log_n = 0;
      push_word(make_word(8'h80), 1'b1, 7'd64);
      push_word(make_word(8'h90), 1'b1, 7'd64);
      push_word(make_word(8'hA0), 1'b1, 7'd64);
      mm = 0;
      while (log_n < 4 && mm < 100) begin
         mm++;
         @(negedge clk);
         #1;
      end
      check("t5_at_beat3",  64'(log_n), 64'd4);
      check("t5_level_pre", 64'(tif.fifo_level), 64'd2);
      reset = 1'b1;
      exp_q.delete();
      prev_stall = 1'b0;
      #1;
      check("t5_rst_tvalid", 64'(tif.m_axis_tvalid), 64'd0);
      check("t5_rst_level",  64'(tif.fifo_level), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      log_n = 0;
      push_word(make_word(8'hC0), 1'b1, 7'd8);
      wait_drain();
      check("t5_count", 64'(log_n), 64'd1);
      check("t5_beat0", log_d[0], 64'hC7C6C5C4C3C2C1C0);
      check("t5_last0", 64'(log_l[0]), 64'd1);

      // bytes = 0 on a last word means a full word.
      log_n = 0;
      push_word(make_word(8'h20), 1'b1, 7'd0);
      wait_drain();
      check("t6_count", 64'(log_n), 64'd8);
      check("t6_keep7", 64'(log_k[7]), 64'hFF);
      check("t6_last0", 64'(log_l[0]), 64'd0);
      check("t6_last7", 64'(log_l[7]), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tx_stream_packer.md
# tx_stream_packer

Downstream neighbour of the BRAM read stage: accepts the 512-bit words that stage places on `fifo_tx_data`, buffers them in a small internal FIFO, and serializes each word into 64-bit AXI-Stream beats toward the MAC/TX path. It supplies back-pressure to the read stage via `fifo_tx_ready`. Segment boundaries are marked by `word_last`, and the final word may be partial (`word_bytes`), producing correct `m_axis_tkeep` and `m_axis_tlast`.

## Interface
- `data_bits`, 512, input word width; must equal `out_bits * beats`.
- `out_bits`, 64, output beat width.
- `fifo_depth`, 4, input FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; one clock, asynchronous active-high reset as decided.
- `fifo_tx_data`  in  data_bits  word from read stage.
- `fifo_tx_valid`  in  1  word present.
- `word_last`  in  1  word is last of segment.
- `word_bytes`  in  7  valid bytes in word (1..64); sampled only with `word_last`, otherwise 64 implied.
- `fifo_tx_ready`  out  1  FIFO can accept (= !full).
- `m_axis_tdata`  out  out_bits  beat data.
- `m_axis_tkeep`  out  out_bits/8  byte enables.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tlast`  out  1  final beat of segment.
- `m_axis_tready`  in  1  sink accept.
- `fifo_level`  out  clog2(fifo_depth)+1  current FIFO occupancy.

## Operation
- Reset values: `fifo_tx_ready`=1, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `fifo_level`=0; FIFO pointers and beat counter cleared.
- Push: `fifo_tx_valid && fifo_tx_ready` writes {data, last, bytes} into FIFO. Bytes values 0 or >64 are treated as 64.
- `fifo_tx_ready` is derived from registered full only; no pass-through when full, even if a pop occurs in the same cycle.
- Serializer FSM:
  - IDLE: if FIFO is not empty, pop the head into the shift register; compute `nbeats` = last ? ceil(bytes/8) : 8; set beat=0; go to SEND.
  - SEND: drive beat k = word[64k+63:64k] (little-endian lanes). Advance beat on `tvalid && tready`.
  - On the final beat handshake: if FIFO is not empty, reload the next word in the same cycle and stay in SEND (back-to-back, no bubble); else go to IDLE.
- `tkeep` = 0xFF except on the final beat of a last word, where it is (1<<(bytes-8*(nbeats-1)))-1 (e.g., 3 residual bytes → 0x07).
- `tlast` = 1 only on the final beat of a word with last=1.
- Data and tkeep stay stable while `tvalid && !tready` (AXI-S rule). `tvalid` never drops without a handshake.
- Simultaneous push and pop: `fifo_level` unchanged; pointers both advance and wrap modulo `fifo_depth`.
- Reset mid-segment: the partial segment is discarded. After release, output resumes only with newly pushed words.

## Timing
- Word pushed at edge N into an empty FIFO while in IDLE: first beat has `tvalid`=1 after edge N+2 (edge N+1 performs the pop/load).
- Sustained throughput: one beat per cycle with `tready`=1, i.e., one 512-bit word per 8 cycles. The read stage must stall via `fifo_tx_ready`.
- No combinational path from `m_axis_tready` to `fifo_tx_ready`. All outputs are registered except `m_axis_tdata`/`tkeep`, which are muxed from the registered shift register and beat counter.

## Structure
- Shared package `tcp_tx_pkg`: `BEATS = data_bits/out_bits`, the keep-mask function, and the FSM state typedef {IDLE, SEND}.
- Sub-module `tx_sync_fifo` (parameterized width/depth, registered full/empty, level output). The serializer FSM stays in the top.

## Test plan
- Reset, then push one word 0x…3F3E…0100 (byte i = i) with last=1, bytes=64, tready=1 → 8 beats; beat0 = 0x0706050403020100; tkeep=0xFF on all beats; tlast on beat 7 only.
- Push a last word with bytes=19 → 3 beats; tkeep = FF, FF, 07; tlast on beat 2.
- Push 6 words back-to-back with tready=1 → `fifo_tx_ready` drops when `fifo_level`=4; 48 contiguous beats with no bubble between words.
- Toggle tready randomly at 50% → data and tkeep held during stalls; beat sequence identical to the tready=1 run.
- Assert reset for 1 cycle during beat 3 of a word with 2 words queued → `tvalid` immediately 0 and level=0; next pushed word is output from beat 0.
- Push word with last=1, bytes=0 → treated as 64: 8 beats, tkeep=0xFF, tlast on beat 7.
